truth_table_scanner: RTL and testbench
======================================

# truth_table_scanner

Sequential stimulus-and-capture stage wrapped around a small combinational gate under test, such as the 2-input AND exercise block. On `start` it walks every input combination in binary order and drives it to the gate. After a programmable settle time it samples the gate's output and assembles the full truth table into one word. It then compares that word against an expected table and reports pass/fail with a `done` pulse, so gate exercises can be self-checked in hardware or simulation.

## Interface
- `N_INPUTS`, default 2: number of gate inputs; range 1..6; table width `W = 2**N_INPUTS`.
- `SETTLE`, default 1: idle cycles between applying a vector and sampling; range 0..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `start`  in  1  request a scan; accepted only in IDLE.
- `expected`  in  W  expected truth table; bit i = required output for input vector i; captured at start acceptance.
- `f_in`  in  1  output of the gate under test.
- `vec`  out  N_INPUTS  input vector to the gate; `vec[N_INPUTS-1]` drives the first input (`a`), `vec[0]` the last (`b`).
- `table_out`  out  W  captured truth table; bit i = `f_in` sampled while `vec == i`.
- `busy`  out  1  high from start acceptance until the DONE state is entered.
- `done`  out  1  one-cycle pulse; scan complete.
- `pass`  out  1  `table_out == expected`; valid from `done` until the next start acceptance.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - `start` is sampled high: capture `expected`, clear `table_out`, set `vec = 0`, clear `pass`, load the settle counter.
  - Then go to SETTLE, or directly to SAMPLE if `SETTLE == 0`.
- **SETTLE**
  - Counter counts down SETTLE cycles, then the FSM goes to SAMPLE.
  - `vec` is held stable throughout.
- **SAMPLE**
  - `table_out[vec] <= f_in`.
  - If `vec == W-1`: go to DONE.
  - Otherwise: `vec <= vec+1`, reload the counter, go to SETTLE (or stay in SAMPLE if `SETTLE == 0`).
- **DONE**
  - `done = 1` for exactly one cycle.
  - `pass <= (table_out == expected_q)`, computed with the final bit included.
  - Next state is IDLE.
- `vec` holds its last value in IDLE. It does not wrap back to 0 until the next start.
- `start` while `busy` or in DONE is ignored; no queuing.
- `expected` changing mid-scan has no effect, because the captured copy is used.
- `f_in` is only sampled in SAMPLE; glitches during SETTLE are ignored.

## Timing
- Reset values: `vec = 0`, `table_out = 0`, `busy = 0`, `done = 0`, `pass = 0`; state IDLE; counter 0.
- Each vector occupies `SETTLE+1` cycles.
- Start-accept edge to `done` high: `W*(SETTLE+1)` cycles.
  - Defaults (`W = 4`, `SETTLE = 1`): 8 cycles.
- `busy` rises on the cycle after start acceptance and falls when DONE is entered; it is low during the `done` cycle.
- `pass` and `table_out` are registered. Both are stable in the `done` cycle and afterwards.
- `rst` asserted mid-scan: all outputs go to their reset values immediately (asynchronously); the partial table is discarded.
- `start` held high continuously: a new scan begins on the cycle after DONE, once back in IDLE.

## Configuration
- `TT_MISMATCH_COUNT_EN` defined:
  - Adds output `err_cnt` (width `N_INPUTS+1`), cleared at start acceptance.
  - `err_cnt` increments in SAMPLE whenever `f_in != expected_q[vec]`.
  - Final value is valid with `done`; reset value 0.
- `TT_MISMATCH_COUNT_EN` undefined: no `err_cnt` port and no counter logic. All other behaviour is identical.

## Structure
- Package `tt_scan_pkg` holds:
  - state encoding `tt_state_t` (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3);
  - settle counter width constant `TT_SETTLE_W = 4`.
- One sub-module, `tt_settle_timer`: loadable down-counter with `load` and `expired` signals. The FSM, table capture and comparison stay in the top module.

## Test plan
- AND gate as DUT, `expected = 4'b1000`, start pulse → `vec` sequence 0,1,2,3; `table_out = 4'b1000`; `pass = 1`; `done` exactly 8 cycles after acceptance.
- Same setup with `expected = 4'b1110` (OR table) → `table_out = 4'b1000`, `pass = 0`; with the macro defined, `err_cnt = 2`.
- `SETTLE = 0`, `N_INPUTS = 3`, XOR3 DUT, `expected = 8'b10010110` → `pass = 1`; `done` 8 cycles after acceptance.
- `start` pulsed again at the 3rd cycle of a scan → ignored; a single `done`; `vec` never restarts mid-scan.
- `rst` asserted during the SAMPLE of `vec = 2` → all outputs 0 in the same cycle; next start runs a full scan from `vec = 0`.
- `expected` changed to 0 mid-scan with a correct AND DUT → `pass = 1`, because the captured value is used.

Source files
------------

// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_scan_pkg;

  typedef enum logic [1:0] {
    TT_IDLE   = 2'd0,
    TT_SETTLE = 2'd1,
    TT_SAMPLE = 2'd2,
    TT_DONE   = 2'd3
  } tt_state_t;

  localparam int unsigned TT_SETTLE_W = 4;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags the last settle cycle of a vector.
module tt_settle_timer
  import tt_scan_pkg::*;
#(
  parameter int unsigned WIDTH = TT_SETTLE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (en && count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  // Expired on the final count so the FSM leaves SETTLE after exactly `value` cycles.
  assign expired = (count_q <= WIDTH'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all input vectors of a gate under test, captures its truth table and
// compares it with an expected table. Define TT_MISMATCH_COUNT_EN to add err_cnt.
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int unsigned N_INPUTS = 2,
  parameter int unsigned SETTLE   = 1,
  localparam int unsigned W       = 2 ** N_INPUTS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        expected,
  input  logic                f_in,
  output logic [N_INPUTS-1:0] vec,
  output logic [W-1:0]        table_out,
  output logic                busy,
  output logic                done,
  output logic                pass
`ifdef TT_MISMATCH_COUNT_EN
  ,
  output logic [N_INPUTS:0]   err_cnt
`endif
);

  localparam logic [TT_SETTLE_W-1:0] SETTLE_LD  = TT_SETTLE_W'(SETTLE);
  localparam tt_state_t              AFTER_LOAD = (SETTLE == 0) ? TT_SAMPLE : TT_SETTLE;

  tt_state_t   state_q, state_d;
  logic [W-1:0] expected_q;
  logic [W-1:0] tbl_next;
  logic         accept;
  logic         last_vec;
  logic         timer_load;
  logic         timer_expired;

  assign accept   = (state_q == TT_IDLE) && start;
  assign last_vec = (vec == {N_INPUTS{1'b1}});
  assign busy     = (state_q == TT_SETTLE) || (state_q == TT_SAMPLE);
  assign done     = (state_q == TT_DONE);

  tt_settle_timer #(.WIDTH(TT_SETTLE_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .value   (SETTLE_LD),
    .en      (state_q == TT_SETTLE),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TT_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    case (state_q)
      TT_IDLE: begin
        if (start) begin
          timer_load = 1'b1;
          state_d    = AFTER_LOAD;
        end
      end
      TT_SETTLE: begin
        if (timer_expired) state_d = TT_SAMPLE;
      end
      TT_SAMPLE: begin
        if (last_vec) begin
          state_d = TT_DONE;
        end else begin
          timer_load = 1'b1;
          state_d    = AFTER_LOAD;
        end
      end
      TT_DONE: state_d = TT_IDLE;
      default: state_d = TT_IDLE;
    endcase
  end

  // Table with the current sample merged in, so pass includes the final bit.
  always_comb begin
    tbl_next      = table_out;
    tbl_next[vec] = f_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected_q <= '0;
      table_out  <= '0;
      vec        <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      expected_q <= expected;
      table_out  <= '0;
      vec        <= '0;
      pass       <= 1'b0;
    end else if (state_q == TT_SAMPLE) begin
      table_out <= tbl_next;
      if (last_vec) pass <= (tbl_next == expected_q);
      else          vec  <= vec + N_INPUTS'(1);
    end
  end

`ifdef TT_MISMATCH_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept) begin
      err_cnt <= '0;
    end else if (state_q == TT_SAMPLE && f_in != expected_q[vec]) begin
      err_cnt <= err_cnt + (N_INPUTS + 1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: two instances (2-input/settle 1 and
// 3-input/settle 0) driven by gate models, checked against a behavioural model.
module tb_truth_table_scanner;

  localparam int NA = 2, SA = 1, WA = 4;
  localparam int NB = 3, SB = 0, WB = 8;
  localparam int K_AND = 0, K_OR = 1, K_XOR = 2, K_LUT = 3;

  typedef struct {
    int         d;
    int         accept;
    logic [7:0] tbl;
    bit         pass;
    int         err;
  } scan_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  scan_t sb[$];

  logic          start_a, start_b;
  logic [WA-1:0] exp_a;
  logic [WB-1:0] exp_b;
  logic          f_a, f_b, glitch_a;
  logic [NA-1:0] vec_a;
  logic [NB-1:0] vec_b;
  logic [WA-1:0] tbl_a;
  logic [WB-1:0] tbl_b;
  logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [NA:0]   err_a;
  logic [NB:0]   err_b;
  int            kind_a, kind_b;
  logic [7:0]    lut_a, lut_b;

  // Gate models, expressed directly as Boolean functions of the vector index.
  function automatic bit gate_fn(input int kind, input int n, input logic [7:0] lut, input int v);
    case (kind)
      K_AND:   return v == (1 << n) - 1;
      K_OR:    return v != 0;
      K_XOR:   return ($countones(v) % 2) == 1;
      default: return lut[v];
    endcase
  endfunction

  function automatic logic [7:0] model_tbl(input int kind, input int n, input logic [7:0] lut);
    logic [7:0] t;
    t = '0;
    for (int v = 0; v < (1 << n); v++) t[v] = gate_fn(kind, n, lut, v);
    return t;
  endfunction

  always_comb f_a = gate_fn(kind_a, NA, lut_a, int'(vec_a)) ^ glitch_a;
  always_comb f_b = gate_fn(kind_b, NB, lut_b, int'(vec_b));

  truth_table_scanner #(.N_INPUTS(NA), .SETTLE(SA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(exp_a), .f_in(f_a),
    .vec(vec_a), .table_out(tbl_a), .busy(busy_a), .done(done_a), .pass(pass_a)
`ifdef TT_MISMATCH_COUNT_EN
    , .err_cnt(err_a)
`endif
  );

  truth_table_scanner #(.N_INPUTS(NB), .SETTLE(SB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(exp_b), .f_in(f_b),
    .vec(vec_b), .table_out(tbl_b), .busy(busy_b), .done(done_b), .pass(pass_b)
`ifdef TT_MISMATCH_COUNT_EN
    , .err_cnt(err_b)
`endif
  );

`ifndef TT_MISMATCH_COUNT_EN
  assign err_a = '0;
  assign err_b = '0;
`endif

  logic [7:0] vec_s[2], tbl_s[2];
  logic       busy_s[2], done_s[2], pass_s[2];
  int         err_s[2];
  always_comb begin
    vec_s[0] = 8'(vec_a);  vec_s[1] = 8'(vec_b);
    tbl_s[0] = 8'(tbl_a);  tbl_s[1] = 8'(tbl_b);
    busy_s[0] = busy_a;    busy_s[1] = busy_b;
    done_s[0] = done_a;    done_s[1] = done_b;
    pass_s[0] = pass_a;    pass_s[1] = pass_b;
    err_s[0] = int'(err_a); err_s[1] = int'(err_b);
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: tracks scan progress from the acceptance cycle and compares on done.
  int mj, mlat, ms, mw;
  always @(negedge clk) begin
    glitch_a = 1'b0;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (sb.size() > 0 && sb[0].d == d) begin
          ms   = d ? SB : SA;
          mw   = d ? WB : WA;
          mlat = mw * (ms + 1);
          mj   = cyc - sb[0].accept;
          if (mj < mlat) begin
            check("done_early", int'(done_s[d]), 0);
            check("busy_scan", int'(busy_s[d]), 1);
            check("vec_seq", int'(vec_s[d]), mj / (ms + 1));
            // Glitch only in cycles that are not followed by a sampling edge.
            if (d == 0 && (mj % (ms + 1)) != ms) glitch_a = 1'($urandom_range(0, 1));
          end else begin
            check("done_latency", int'(done_s[d]), 1);
            check("busy_in_done", int'(busy_s[d]), 0);
            check("table_out", int'(tbl_s[d]), int'(sb[0].tbl));
            check("pass", int'(pass_s[d]), int'(sb[0].pass));
            check("vec_last", int'(vec_s[d]), mw - 1);
`ifdef TT_MISMATCH_COUNT_EN
            check("err_cnt", err_s[d], sb[0].err);
`endif
            void'(sb.pop_front());
          end
        end else begin
          check("no_spurious_done", int'(done_s[d]), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_vec_a", int'(vec_a), 0);     check("rst_tbl_a", int'(tbl_a), 0);
    check("rst_busy_a", int'(busy_a), 0);   check("rst_done_a", int'(done_a), 0);
    check("rst_pass_a", int'(pass_a), 0);   check("rst_err_a", int'(err_a), 0);
    check("rst_vec_b", int'(vec_b), 0);     check("rst_tbl_b", int'(tbl_b), 0);
    check("rst_busy_b", int'(busy_b), 0);   check("rst_pass_b", int'(pass_b), 0);
  endtask

  // One scan on DUT d. poke_j >= 0 re-pulses start in scan cycle poke_j;
  // rst_j >= 0 asserts reset in scan cycle rst_j and abandons the scan.
  task automatic do_scan(input int d, input int kind, input logic [7:0] lut,
                         input logic [7:0] expv, input int poke_j, input int rst_j);
    scan_t      it;
    int         n, w;
    logic [7:0] mask;
    n    = d ? NB : NA;
    w    = d ? WB : WA;
    mask = 8'((1 << w) - 1);
    @(negedge clk);
    if (d == 0) begin kind_a = kind; lut_a = lut; exp_a = expv[WA-1:0]; start_a = 1'b1; end
    else        begin kind_b = kind; lut_b = lut; exp_b = expv;         start_b = 1'b1; end
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    it.d      = d;
    it.accept = cyc;
    it.tbl    = model_tbl(kind, n, lut);
    it.pass   = (it.tbl == (expv & mask));
    it.err    = $countones((it.tbl ^ expv) & mask);
    sb.push_back(it);
    // The scanner must keep using the value captured at acceptance.
    exp_a = WA'($urandom);
    exp_b = WB'($urandom);
    if (poke_j >= 0) begin
      repeat (poke_j + 1) @(negedge clk);
      if (d == 0) start_a = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
    end
    if (rst_j >= 0) begin
      repeat (rst_j + 1) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs();
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      check("scan_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
    check("pass_hold", int'(pass_s[d]), int'(it.pass));
    check("table_hold", int'(tbl_s[d]), int'(it.tbl));
    check("vec_hold", int'(vec_s[d]), w - 1);
  endtask

  initial begin
    logic [7:0] lut, tbl, expv;
    int         d, kind;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; exp_a = '0; exp_b = '0;
    kind_a = K_AND; kind_b = K_XOR; lut_a = '0; lut_b = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    do_scan(0, K_AND, 8'h00, 8'h08, -1, -1);   // AND, correct table
    do_scan(0, K_AND, 8'h00, 8'h0E, -1, -1);   // AND against OR table
    do_scan(1, K_XOR, 8'h00, 8'h96, -1, -1);   // XOR3, settle 0
    do_scan(0, K_AND, 8'h00, 8'h08, 2, -1);    // start re-pulsed mid-scan
    do_scan(0, K_AND, 8'h00, 8'h08, -1, 5);    // reset during SAMPLE of vec 2
    do_scan(0, K_AND, 8'h00, 8'h08, -1, -1);   // full scan after reset

    for (int i = 0; i < 24; i++) begin
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 3));
      lut  = 8'($urandom);
      tbl  = model_tbl(kind, d ? NB : NA, lut);
      expv = ($urandom_range(0, 1) == 1) ? tbl : 8'($urandom);
      do_scan(d, kind, lut, expv, -1, -1);
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
